// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: command-side master for the combinational 8-bit ALU.
// Accepts op/operand/tag commands over valid/ready and drives the ALU inputs.
// After SETTLE cycles it captures the result and flags.
// It returns them with the tag over a response valid/ready channel.
// Ports:
//   clk, rst (sync, active-high)
//   cmd_valid/cmd_ready, cmd_op, cmd_a, cmd_b, cmd_tag     command channel
//   alu_A, alu_B, alu_OPcode, alu_carry_in                 to ALU
//   alu_out, alu_c_flag, alu_carry_out                     from ALU
//   rsp_valid/rsp_ready, rsp_data, rsp_gt, rsp_carry,
//   rsp_op, rsp_tag                                        response channel
//   busy, cmd_count                                        status
module alu_cmd_driver #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [3:0]       cmd_tag,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [2:0]       alu_OPcode,
   output logic             alu_carry_in,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_c_flag,
   input  logic             alu_carry_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_gt,
   output logic             rsp_carry,
   output logic [2:0]       rsp_op,
   output logic [3:0]       rsp_tag,
   output logic             busy,
   output logic [CNT_W-1:0] cmd_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [3:0] settle_cnt;
   logic [2:0] op_q;
   logic [3:0] tag_q;
   logic       cmd_hs;
   logic       rsp_hs;
   logic       settle_done;

   // cmd_ready never looks at cmd_valid, so no comb loop with the sequencer.
   assign cmd_ready   = (state == IDLE) | ((state == RESP) & rsp_ready);
   assign cmd_hs      = cmd_valid & cmd_ready;
   assign rsp_valid   = (state == RESP);
   assign rsp_hs      = rsp_valid & rsp_ready;
   assign busy        = (state != IDLE);
   assign settle_done = (settle_cnt == 4'(SETTLE - 1));

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (cmd_hs) state_nx = DRIVE;
         DRIVE:   if (settle_done) state_nx = RESP;
         RESP:    if (rsp_hs) state_nx = cmd_hs ? DRIVE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         settle_cnt   <= '0;
         op_q         <= '0;
         tag_q        <= '0;
         alu_A        <= '0;
         alu_B        <= '0;
         alu_OPcode   <= '0;
         alu_carry_in <= 1'b0;
         rsp_data     <= '0;
         rsp_gt       <= 1'b0;
         rsp_carry    <= 1'b0;
         rsp_op       <= '0;
         rsp_tag      <= '0;
         cmd_count    <= '0;
      end else begin
         state <= state_nx;
         if (cmd_hs) begin
            alu_A        <= cmd_a;
            alu_B        <= cmd_b;
            alu_OPcode   <= cmd_op;
            // op 001 is the carry-in variant; everything else runs with cin=0
            alu_carry_in <= (cmd_op == 3'b001);
            op_q         <= cmd_op;
            tag_q        <= cmd_tag;
            settle_cnt   <= '0;
         end else if ((state == DRIVE) && !settle_done) begin
            settle_cnt <= settle_cnt + 4'd1;
         end
         if ((state == DRIVE) && settle_done) begin
            rsp_data  <= alu_out;
            rsp_gt    <= alu_c_flag;
            // carry_out is only meaningful for the two arithmetic ops
            rsp_carry <= (op_q[2:1] == 2'b00) & alu_carry_out;
            rsp_op    <= op_q;
            rsp_tag   <= tag_q;
         end
         if (rsp_hs) cmd_count <= cmd_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed bench for alu_cmd_driver (SETTLE=3, CNT_W=2).
// A small behavioural ALU closes the loop on the alu_* ports.
module tb_alu_cmd_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic [3:0] cmd_tag;
   logic [7:0] alu_A;
   logic [7:0] alu_B;
   logic [2:0] alu_OPcode;
   logic       alu_carry_in;
   logic [7:0] alu_out;
   logic       alu_c_flag;
   logic       alu_carry_out;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_gt;
   logic       rsp_carry;
   logic [2:0] rsp_op;
   logic [3:0] rsp_tag;
   logic       busy;
   logic [1:0] cmd_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_cmd_driver #(
      .WIDTH (8),
      .SETTLE(3),
      .CNT_W (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_tag      (cmd_tag),
      .alu_A        (alu_A),
      .alu_B        (alu_B),
      .alu_OPcode   (alu_OPcode),
      .alu_carry_in (alu_carry_in),
      .alu_out      (alu_out),
      .alu_c_flag   (alu_c_flag),
      .alu_carry_out(alu_carry_out),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_gt       (rsp_gt),
      .rsp_carry    (rsp_carry),
      .rsp_op       (rsp_op),
      .rsp_tag      (rsp_tag),
      .busy         (busy),
      .cmd_count    (cmd_count)
   );

   // Behavioural ALU; carry_out is deliberately 1 on logic ops.
   logic [8:0] sum;
   always_comb begin
      sum           = 9'd0;
      alu_out       = 8'd0;
      alu_carry_out = 1'b1;
      alu_c_flag    = (alu_A > alu_B);
      case (alu_OPcode)
         3'b000: begin
            sum           = {1'b0, alu_A} + {1'b0, alu_B} + {8'd0, alu_carry_in};
            alu_out       = sum[7:0];
            alu_carry_out = sum[8];
         end
         3'b001: begin
            sum           = {1'b0, alu_A} + {1'b0, ~alu_B} + {8'd0, alu_carry_in};
            alu_out       = sum[7:0];
            alu_carry_out = sum[8];
         end
         3'b010:  alu_out = alu_A & alu_B;
         3'b011:  alu_out = alu_A | alu_B;
         3'b100:  alu_out = alu_A ^ alu_B;
         default: alu_out = ~alu_A;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Count cycles from the accept edge until rsp_valid, bounded.
   task automatic wait_rsp(input string tag, input int exp_cyc);
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
         step();
         n++;
      end
      chk(tag, n, exp_cyc);
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] tag);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_tag   = tag;
   endtask

   int         seen;
   int         nrsp;
   int         cyc;
   int         idx;
   logic       hs;
   int         rec_cyc  [5];
   logic [3:0] rec_tag  [5];
   logic [7:0] rec_data [5];

   initial begin
      rst       = 1'b1;
      rsp_ready = 1'b0;
      send(3'b000, 8'h00, 8'h00, 4'h0);
      cmd_valid = 1'b0;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_A", alu_A, 0);
      chk("rst_alu_B", alu_B, 0);
      chk("rst_alu_op", alu_OPcode, 0);
      chk("rst_alu_cin", alu_carry_in, 0);
      chk("rst_count", cmd_count, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_tag", rsp_tag, 0);

      // OR command
      @(negedge clk);
      send(3'b011, 8'hA0, 8'h0A, 4'd5);
      step();
      cmd_valid = 1'b0;
      chk("or_busy", busy, 1);
      chk("or_cmd_ready", cmd_ready, 0);
      chk("or_alu_A", alu_A, 8'hA0);
      chk("or_alu_B", alu_B, 8'h0A);
      chk("or_alu_op", alu_OPcode, 3'b011);
      chk("or_alu_cin", alu_carry_in, 0);
      wait_rsp("or_latency", 3);
      chk("or_data", rsp_data, 8'hAA);
      chk("or_gt", rsp_gt, 1);
      chk("or_carry", rsp_carry, 0);
      chk("or_tag", rsp_tag, 5);
      chk("or_op", rsp_op, 3'b011);
      rsp_ready = 1'b1;
      #1;
      chk("or_ready_in_resp", cmd_ready, 1);
      step();
      rsp_ready = 1'b0;
      chk("or_rsp_drop", rsp_valid, 0);
      chk("or_idle", busy, 0);
      chk("or_count", cmd_count, 1);
      chk("or_alu_hold", alu_A, 8'hA0);

      // ADD overflow
      send(3'b000, 8'hFF, 8'h01, 4'd6);
      step();
      cmd_valid = 1'b0;
      chk("add_alu_cin", alu_carry_in, 0);
      wait_rsp("add_latency", 3);
      chk("add_data", rsp_data, 8'h00);
      chk("add_carry", rsp_carry, 1);
      chk("add_gt", rsp_gt, 1);
      chk("add_tag", rsp_tag, 6);

      // Backpressure with pending next command (op 001)
      send(3'b001, 8'h05, 8'h03, 4'd7);
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_data", rsp_data, 8'h00);
         chk("bp_tag", rsp_tag, 6);
         chk("bp_alu_A", alu_A, 8'hFF);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("dual_rsp_drop", rsp_valid, 0);
      chk("dual_busy", busy, 1);
      chk("dual_count", cmd_count, 2);
      chk("sub_alu_A", alu_A, 8'h05);
      chk("sub_alu_op", alu_OPcode, 3'b001);
      chk("sub_alu_cin", alu_carry_in, 1);
      wait_rsp("sub_latency", 3);
      chk("sub_data", rsp_data, 8'h02);
      chk("sub_carry", rsp_carry, 1);
      chk("sub_tag", rsp_tag, 7);
      chk("sub_op", rsp_op, 3'b001);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("sub_count", cmd_count, 3);

      // Reset in DRIVE drops the command
      send(3'b010, 8'h3C, 8'h0F, 4'd9);
      step();
      cmd_valid = 1'b0;
      step();
      chk("rd_busy_pre", busy, 1);
      rst = 1'b1;
      step();
      chk("rd_busy", busy, 0);
      chk("rd_rsp_valid", rsp_valid, 0);
      chk("rd_cmd_ready", cmd_ready, 1);
      chk("rd_alu_A", alu_A, 0);
      chk("rd_count", cmd_count, 0);
      step();
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid) seen++;
         step();
      end
      chk("rd_no_rsp", seen, 0);

      // Five back-to-back XOR commands
      rsp_ready = 1'b1;
      idx  = 0;
      nrsp = 0;
      cyc  = 0;
      send(3'b100, 8'h10, 8'h0F, 4'd8);
      while (nrsp < 5 && cyc < 40) begin
         if (rsp_valid) begin
            rec_cyc[nrsp]  = cyc;
            rec_tag[nrsp]  = rsp_tag;
            rec_data[nrsp] = rsp_data;
            nrsp++;
         end
         hs = cmd_valid & cmd_ready;
         step();
         cyc++;
         if (hs) begin
            idx++;
            if (idx < 5) send(3'b100, 8'h10 + 8'(idx), 8'h0F, 4'(8 + idx));
            else cmd_valid = 1'b0;
         end
      end
      rsp_ready = 1'b0;
      chk("b2b_nrsp", nrsp, 5);
      for (int i = 0; i < nrsp; i++) begin
         chk("b2b_tag", rec_tag[i], 8 + i);
         chk("b2b_data", rec_data[i], 8'h1F - 8'(i));
         if (i > 0) chk("b2b_spacing", rec_cyc[i] - rec_cyc[i-1], 4);
      end
      chk("b2b_count_wrap", cmd_count, 1);
      chk("b2b_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
